// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit and the decode logic that drives it.
// Holds FSM encoding, result-select codes, funct codes and the iteration count.
package hilo_mult_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_HI  = 2'b01;
  localparam logic [1:0] MUX_LO  = 2'b10;

  localparam logic [5:0] FUNCT_MULT = 6'd24;
  localparam logic [5:0] FUNCT_MFHI = 6'd16;
  localparam logic [5:0] FUNCT_MFLO = 6'd18;

  localparam int MULT_CYCLES = 32;

  // Magnitude as unsigned 32 bits; 0x80000000 maps to 2^31 without overflow.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned 32x32 shift-add datapath: one partial product per step, 64-bit accumulator.
// load clears the accumulator/counter and latches operand magnitudes; last flags the final step.
module mult_shift_add_core
  import hilo_mult_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplier_in,
  output logic [63:0] acc,
  output logic        last
);

  logic [63:0] mcand_sh;
  logic [31:0] mplier_sh;
  logic [5:0]  cnt;

  assign last = step && (cnt == 6'(MULT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      cnt       <= '0;
    end else if (load) begin
      acc       <= '0;
      mcand_sh  <= {32'd0, mcand_in};
      mplier_sh <= mplier_in;
      cnt       <= '0;
    end else if (step) begin
      // Multiplier LSB gates the shifted multiplicand into the running sum.
      if (mplier_sh[0])
        acc <= acc + mcand_sh;
      mcand_sh  <= {mcand_sh[62:0], 1'b0};
      mplier_sh <= {1'b0, mplier_sh[31:1]};
      cnt       <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// Signed multiply unit with HI/LO registers, IDLE/CALC/FIX sequencer and writeback mux.
// 34-cycle latency from accepted start to HI/LO update; stall holds dependent instructions.
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  alu_mux,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] alu_result,
  output logic [31:0] result,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  state_e      state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        sign;
  logic [63:0] acc;
  logic [63:0] product;
  logic        last;
  logic        accept;

  assign accept  = (state == ST_IDLE) && start;
  assign product = sign ? (~acc + 64'd1) : acc;

  mult_shift_add_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (state == ST_CALC),
    .mcand_in  (mag32(op_a)),
    .mplier_in (mag32(op_b)),
    .acc       (acc),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      hi    <= '0;
      lo    <= '0;
      sign  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign  <= op_a[31] ^ op_b[31];
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (last) begin
            done  <= 1'b1;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi    <= product[63:32];
          lo    <= product[31:0];
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    result = alu_result;
    case (alu_mux)
      MUX_HI:  result = hi;
      MUX_LO:  result = lo;
      default: result = alu_result;
    endcase
  end

  assign stall = busy && (start || alu_mux == MUX_HI || alu_mux == MUX_LO);

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Bench for hilo_mult_unit: cycle-level reference model with a per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hilo_mult_unit;
  import hilo_mult_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  alu_mux = 2'b00;
  logic [31:0] op_a = '0, op_b = '0, alu_result = '0;
  logic [31:0] result;
  logic        busy, stall, done;

  int checks = 0;
  int failures = 0;

  hilo_mult_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_mux(alu_mux),
    .op_a(op_a), .op_b(op_b), .alu_result(alu_result),
    .result(result), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request completes 34 cycles later; m_rem counts cycles left.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_prod = '0;
  longint      pa, pb;
  int          m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_rem == 0) begin
      if (start) begin
        pa = $signed(op_a);
        pb = $signed(op_b);
        m_prod = pa * pb;
        m_rem = 33;
      end
    end else begin
      if (m_rem == 1) begin
        m_hi = m_prod[63:32];
        m_lo = m_prod[31:0];
      end
      m_rem--;
    end
  end

  always @(posedge clk) begin
    logic [31:0] exp_res;
    #1;
    exp_res = (alu_mux == MUX_HI) ? m_hi : (alu_mux == MUX_LO) ? m_lo : alu_result;
    check("cyc_busy", busy, m_rem > 0);
    check("cyc_done", done, m_rem == 1);
    check("cyc_stall", stall, (m_rem > 0) && (start || alu_mux == MUX_HI || alu_mux == MUX_LO));
    check("cyc_result", result, exp_res);
  end

  task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    alu_mux = MUX_HI; #1 check({name, "_hi"}, result, ehi);
    alu_mux = MUX_LO; #1 check({name, "_lo"}, result, elo);
    alu_mux = MUX_ALU;
  endtask

  // Issue one multiply, scramble operands after acceptance, count cycles to done.
  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk); start = 1'b1; op_a = a; op_b = b; alu_mux = MUX_ALU;
    @(negedge clk); start = 1'b0; op_a = $urandom; op_b = $urandom; n = 2;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check({name, "_done_cycle"}, n, 34);
    @(negedge clk);
    read_hilo(name, ehi, elo);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, d, bad;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    read_hilo("rst", 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_mult("m3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    run_mult("mneg1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mult("mmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // mfhi waiting on an in-flight multiply
    @(negedge clk); start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h100;
    @(negedge clk); start = 1'b0; alu_mux = MUX_HI; n = 2; bad = 0;
    while (n < 100) begin
      #1 if (!stall) bad++;
      if (done) break;
      @(negedge clk); n++;
    end
    check("mfhi_stall_held", bad, 0);
    check("mfhi_done_cycle", n, 34);
    @(negedge clk); #1 check("mfhi_new_hi", result, 32'h0000_0012);
    check("mfhi_released", stall, 0);
    alu_mux = MUX_ALU;

    // second multiply requested at cycle 10 of the first
    @(negedge clk); start = 1'b1; op_a = 32'd1000; op_b = 32'hFFFF_FFFD;
    @(negedge clk); start = 1'b0; n = 2;
    while (n < 10) begin @(negedge clk); n++; end
    start = 1'b1; op_a = 32'h0001_0000; op_b = 32'h0003_0000; alu_mux = MUX_LO;
    #1 check("second_start_stall", stall, 1);
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("first_done_cycle", n, 34);
    @(negedge clk); d = 1;
    #1 check("first_lo_intact", result, 32'hFFFF_F448);
    alu_mux = MUX_HI; #1 check("first_hi_intact", result, 32'hFFFF_FFFF);
    alu_mux = MUX_ALU;
    @(negedge clk); start = 1'b0; op_a = $urandom; op_b = $urandom; d = 2;
    while (!done && d < 100) begin @(negedge clk); d++; end
    check("second_done_gap", d, 34);
    @(negedge clk);
    read_hilo("second", 32'h0000_0003, 32'h0000_0000);

    // reset in the middle of a multiply
    @(negedge clk); start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk); start = 1'b0; n = 2;
    while (n < 15) begin @(negedge clk); n++; end
    start = 1'b1; rst_n = 1'b0;
    #1 check("abort_busy", busy, 0);
    check("abort_stall", stall, 0);
    check("abort_done", done, 0);
    read_hilo("abort", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1 check("post_reset_accept", busy, 1);
    @(negedge clk); start = 1'b0; n = 2;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("post_reset_done_cycle", n, 34);
    @(negedge clk);
    read_hilo("post_reset", 32'h0, 32'd42);

    // randomized traffic, model compare does the checking
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      op_a       = rnd_op();
      op_b       = rnd_op();
      alu_mux    = 2'($urandom_range(0, 3));
      alu_result = $urandom;
    end
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  multiply request from decode (HiLoEnable)
- alu_mux  in  2  result select: 00 ALU passthrough, 01 HI, 10 LO
- op_a  in  32  multiplicand (rs), signed
- op_b  in  32  multiplier (rt), signed
- alu_result  in  32  ALU result, passed through when alu_mux=00
- result  out  32  selected writeback value
- busy  out  1  multiply in progress
- stall  out  1  pipeline hold request
- done  out  1  one-cycle pulse when HI/LO are updated
REQ-002 The block SHALL use one clock, clk; rst_n SHALL be asynchronous and active-low.

Function
REQ-003 The block SHALL compute the signed 64-bit product op_a*op_b, writing bits [63:32] to HI and bits [31:0] to LO.
REQ-004 The FSM SHALL have three states, IDLE, CALC and FIX, and reset SHALL place it in IDLE.
REQ-005 In IDLE with start=1, the block SHALL latch |op_a|, |op_b| and the sign (op_a[31] XOR op_b[31]), clear the 64-bit accumulator and the 6-bit counter, and enter CALC.
REQ-006 Each CALC cycle SHALL perform one unsigned shift-add step; CALC SHALL last exactly 32 cycles, then the FSM SHALL enter FIX.
REQ-007 FIX SHALL write HI/LO from the accumulator, two's-complement negated if the latched sign=1, assert done for that cycle, and return to IDLE.
REQ-008 Latency SHALL be 34 cycles from the start edge to HI/LO valid: 1 cycle in IDLE, 32 in CALC, 1 in FIX.
REQ-009 busy SHALL be 1 in CALC and FIX and 0 in IDLE.
REQ-010 When alu_mux=00 or 11, result SHALL equal alu_result combinationally.
REQ-011 When alu_mux=01 or 10, result SHALL equal HI or LO respectively, combinationally.
REQ-012 stall SHALL equal busy AND (start OR alu_mux=01 OR alu_mux=10), combinationally.
REQ-013 A start while busy SHALL be ignored; stall holds the instruction, which issues when the unit returns to IDLE.
REQ-014 A start in the same cycle as FIX SHALL be stalled and accepted in the following IDLE cycle.
REQ-015 During CALC and FIX, HI/LO SHALL keep their previous values until the FIX write.
REQ-016 Operand 0x80000000 SHALL be handled: its magnitude is held as an unsigned 32-bit value of 2^31.
REQ-017 Changes on op_a and op_b after acceptance SHALL NOT affect the product.

Reset
REQ-018 rst_n=0 SHALL immediately set state=IDLE, HI=0, LO=0, accumulator=0, counter=0, busy=0, done=0 and stall=0.
REQ-019 rst_n=0 SHALL abort any multiply in progress mid-operation, with no HI/LO write.
REQ-020 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Structure
REQ-021 A shared package SHALL hold the following, shared with the multiply decode logic:
- the FSM state encoding
- the alu_mux encodings (MUX_ALU=00, MUX_HI=01, MUX_LO=10)
- funct constants FUNCT_MULT=24, FUNCT_MFHI=16, FUNCT_MFLO=18
- MULT_CYCLES=32
REQ-022 The shift-add datapath SHALL be one sub-module, mult_shift_add_core, containing the accumulator and counter; the FSM and HI/LO registers SHALL stay in the top module.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- op_a=3, op_b=5, start 1 cycle -> done at cycle 34; HI=0x00000000, LO=0x0000000F.
- op_a=0xFFFFFFFF, op_b=1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- op_a=0x80000000, op_b=0x80000000 -> HI=0x40000000, LO=0x00000000.
- alu_mux=01 held from cycle 2 after start -> stall=1 through FIX; result=new HI the cycle after done.
- Second start at cycle 10 of a multiply -> stall=1, first product intact; second product correct 34 cycles after the first done.
- rst_n low at cycle 15 of a multiply -> busy=0 immediately, HI=LO=0, no done pulse.
